// File: rtl/vga_timing_gen.sv
// VGA/HDMI raster timing generator: syncs, active-area flags, pixel coordinates,
// a data-request strobe that leads the active area, and a selectable test-pattern output.
module vga_timing_gen #(
   parameter int         H_SYNC    = 44,
   parameter int         H_BACK    = 148,
   parameter int         H_VALID   = 1920,
   parameter int         H_FRONT   = 88,
   parameter int         H_TOTAL   = H_SYNC + H_BACK + H_VALID + H_FRONT,
   parameter int         V_SYNC    = 5,
   parameter int         V_BACK    = 36,
   parameter int         V_VALID   = 1080,
   parameter int         V_FRONT   = 4,
   parameter int         V_TOTAL   = V_SYNC + V_BACK + V_VALID + V_FRONT,
   parameter int         CW        = 12,
   parameter int         DW        = 24,
   parameter int         REQ_LEAD  = 2,
   parameter logic       HS_POL    = 1'b1,
   parameter logic       VS_POL    = 1'b1,
   parameter logic [DW-1:0] PAT_COLOR = DW'(24'hFF0000)
) (
   input  logic          vga_clk,
   input  logic          sys_rst_n,
   input  logic          count_en,
   input  logic [1:0]    pat_sel,
   input  logic [DW-1:0] data_in,
   output logic          hsync,
   output logic          vsync,
   output logic          rgb_valid,
   output logic          data_req,
   output logic [CW-1:0] pix_x,
   output logic [CW-1:0] pix_y,
   output logic          frame_start,
   output logic          line_start,
   output logic          busy,
   output logic [7:0]    frame_cnt,
   output logic [DW-1:0] rgb
);

   localparam int HA    = H_SYNC + H_BACK;
   localparam int VA    = V_SYNC + V_BACK;
   localparam int BAR_W = H_VALID / 8;
   localparam int CC    = DW / 3;

   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_SYNC_C = CW'(H_SYNC);
   localparam logic [CW-1:0] V_SYNC_C = CW'(V_SYNC);
   localparam logic [CW-1:0] HA_C     = CW'(HA);
   localparam logic [CW-1:0] HA_END   = CW'(HA + H_VALID);
   localparam logic [CW-1:0] VA_C     = CW'(VA);
   localparam logic [CW-1:0] VA_END   = CW'(VA + V_VALID);
   localparam logic [CW-1:0] DR_LO    = CW'(HA - REQ_LEAD);
   localparam logic [CW-1:0] DR_HI    = CW'(HA + H_VALID - REQ_LEAD);

   // {R,G,B} on/off per bar: white, yellow, cyan, green, magenta, red, blue, black
   localparam logic [2:0] BARS [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                       3'b101, 3'b100, 3'b001, 3'b000};

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] h_q, h_d, v_q, v_d;
   logic [7:0]    frame_cnt_q, frame_cnt_d;
   logic [1:0]    pat_q, pat_d;
   logic          hsync_q, hsync_d, vsync_q, vsync_d;
   logic          rgb_valid_q, rgb_valid_d, data_req_q, data_req_d;
   logic          frame_start_q, frame_start_d, line_start_q, line_start_d;
   logic [CW-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;

   logic          running, h_last, v_last, h_act, v_act;
   logic [2:0]    bar_c;
   logic [DW-1:0] rgb_d;

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q       <= IDLE;
         h_q           <= '0;
         v_q           <= '0;
         frame_cnt_q   <= '0;
         pat_q         <= '0;
         hsync_q       <= ~HS_POL;
         vsync_q       <= ~VS_POL;
         rgb_valid_q   <= 1'b0;
         data_req_q    <= 1'b0;
         frame_start_q <= 1'b0;
         line_start_q  <= 1'b0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
      end else begin
         state_q       <= state_d;
         h_q           <= h_d;
         v_q           <= v_d;
         frame_cnt_q   <= frame_cnt_d;
         pat_q         <= pat_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         rgb_valid_q   <= rgb_valid_d;
         data_req_q    <= data_req_d;
         frame_start_q <= frame_start_d;
         line_start_q  <= line_start_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      h_d         = h_q;
      v_d         = v_q;
      frame_cnt_d = frame_cnt_q;
      pat_d       = pat_q;
      running     = (state_q != IDLE);
      h_last      = (h_q == H_LAST);
      v_last      = (v_q == V_LAST);

      unique case (state_q)
         IDLE: begin
            h_d = '0;
            v_d = '0;
            if (count_en) state_d = RUN;
         end
         RUN:   if (!count_en) state_d = DRAIN;
         DRAIN: begin
            // Draining only ends on the last position so a frame is never cut short
            if (count_en)             state_d = RUN;
            else if (h_last && v_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (running) begin
         if (h_last) begin
            h_d = '0;
            v_d = v_last ? '0 : v_q + 1'b1;
         end else begin
            h_d = h_q + 1'b1;
         end
         if (h_last && v_last)         frame_cnt_d = frame_cnt_q + 8'd1;
         if (h_q == '0 && v_q == '0)   pat_d = pat_sel;
      end
   end

   always_comb begin
      h_act         = running && (h_q >= HA_C) && (h_q < HA_END);
      v_act         = running && (v_q >= VA_C) && (v_q < VA_END);
      rgb_valid_d   = h_act && v_act;
      data_req_d    = v_act && (h_q >= DR_LO) && (h_q < DR_HI);
      hsync_d       = (running && (h_q < H_SYNC_C)) ? HS_POL : ~HS_POL;
      vsync_d       = (running && (v_q < V_SYNC_C)) ? VS_POL : ~VS_POL;
      pix_x_d       = rgb_valid_d ? h_q - HA_C : '0;
      pix_y_d       = rgb_valid_d ? v_q - VA_C : '0;
      frame_start_d = running && (h_q == '0) && (v_q == '0);
      line_start_d  = v_act && (h_q == HA_C);
   end

   // Pattern generation works off the registered coordinates, so it lines up with rgb_valid
   always_comb begin
      bar_c = 3'b000;
      for (int unsigned i = 0; i < 8; i++) begin
         if (pix_x_q >= CW'(i * BAR_W) && pix_x_q < CW'((i + 1) * BAR_W))
            bar_c = BARS[i];
      end

      rgb_d = '0;
      if (rgb_valid_q) begin
         unique case (pat_q)
            2'd0: rgb_d = data_in;
            2'd1: rgb_d = DW'({{CC{bar_c[2]}}, {CC{bar_c[1]}}, {CC{bar_c[0]}}});
            2'd2: rgb_d = (pix_x_q[5:0] == 6'd0 || pix_y_q[5:0] == 6'd0) ? '1 : '0;
            default: rgb_d = PAT_COLOR;
         endcase
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign rgb_valid   = rgb_valid_q;
   assign data_req    = data_req_q;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign frame_start = frame_start_q;
   assign line_start  = line_start_q;
   assign busy        = (state_q != IDLE);
   assign frame_cnt   = frame_cnt_q;
   assign rgb         = rgb_d;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters H_SYNC (44), H_BACK (148), H_VALID (1920), H_FRONT (88), H_TOTAL = H_SYNC+H_BACK+H_VALID+H_FRONT (derived, 2200 at defaults).
REQ-002 SHALL have parameters V_SYNC (5), V_BACK (36), V_VALID (1080), V_FRONT (4), V_TOTAL = V_SYNC+V_BACK+V_VALID+V_FRONT (derived, 1125 at defaults).
REQ-003 SHALL have parameters CW (12, counter width), DW (24, pixel width), REQ_LEAD (2, data_req lead in cycles, 0..H_BACK), HS_POL (1), VS_POL (1) (1 = active-high sync), PAT_COLOR (24'hFF0000).
REQ-004 SHALL have ports:
- vga_clk in 1 -- pixel clock
- sys_rst_n in 1 -- asynchronous active-low reset
- count_en in 1 -- run request
- pat_sel in 2 -- pattern select
- data_in in DW -- pixel from frame buffer
- hsync out 1
- vsync out 1
- rgb_valid out 1 -- active-area flag
- data_req out 1 -- pixel request
- pix_x out CW -- active column
- pix_y out CW -- active row
- frame_start out 1 -- one-cycle pulse
- line_start out 1 -- one-cycle pulse
- busy out 1 -- timing running
- frame_cnt out 8 -- completed frames
- rgb out DW -- pixel out
REQ-005 The sole clock SHALL be vga_clk; reset SHALL be asynchronous and active-low on sys_rst_n.

Function
REQ-006 Internal counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1) SHALL use CW bits.
REQ-007 h SHALL wrap to 0 at H_TOTAL-1; v SHALL increment on h wrap and wrap to 0 when v=V_TOTAL-1 and h=H_TOTAL-1.
REQ-008 The FSM SHALL have states IDLE, RUN and DRAIN; in IDLE, h=v=0 and counters hold.
REQ-009 Transitions:
- IDLE->RUN when count_en=1; the first RUN cycle is position (0,0).
- RUN->DRAIN when count_en=0.
- DRAIN->RUN when count_en=1, with no counter disturbance.
- DRAIN->IDLE at position (H_TOTAL-1, V_TOTAL-1). Frames are never truncated.
REQ-010 busy SHALL be 1 in RUN and DRAIN, 0 in IDLE.
REQ-011 All timing outputs (hsync, vsync, rgb_valid, data_req, pix_x, pix_y, frame_start, line_start) SHALL be registered, reflecting counter position one cycle later.
REQ-012 Sync active levels:
- hsync active (level HS_POL) for h<H_SYNC.
- vsync active (level VS_POL) for v<V_SYNC.
- Both SHALL be at their inactive levels in IDLE.
REQ-013 Active region:
- HA = H_SYNC+H_BACK; VA = V_SYNC+V_BACK.
- rgb_valid=1 iff HA<=h<HA+H_VALID and VA<=v<VA+V_VALID.
REQ-014 data_req=1 iff HA-REQ_LEAD<=h<HA+H_VALID-REQ_LEAD within active rows: exactly H_VALID cycles per active line, leading rgb_valid by REQ_LEAD.
REQ-015 pix_x=h-HA and pix_y=v-VA while rgb_valid=1; both SHALL be 0 otherwise.
REQ-016 frame_start SHALL pulse for position (0,0); line_start SHALL pulse for h=HA on active rows only.
REQ-017 frame_cnt SHALL increment (mod 256) at each completed frame (h=H_TOTAL-1, v=V_TOTAL-1) in RUN or DRAIN.
REQ-018 pat_sel SHALL be sampled only at position (0,0) and held for the whole frame; a mid-frame change SHALL take effect at the next frame.
REQ-019 Patterns:
- 0: rgb=data_in, combinational, gated by rgb_valid.
- 1: eight vertical colour bars of width H_VALID/8, in order white, yellow, cyan, green, magenta, red, blue, black. Any remainder columns SHALL be black.
- 2: white where pix_x[5:0]=0 or pix_y[5:0]=0, else black.
- 3: PAT_COLOR.
REQ-020 rgb SHALL be 0 whenever rgb_valid=0.
REQ-021 A count_en glitch of one cycle in RUN SHALL only move the FSM to DRAIN and back, with no timing discontinuity.

Reset
REQ-022 While sys_rst_n=0, the block SHALL be in the following state:
- FSM in IDLE, h=v=0, frame_cnt=0, latched pattern=0.
- hsync=~HS_POL, vsync=~VS_POL.
- rgb_valid, data_req, frame_start, line_start, busy all 0.
- pix_x=pix_y=0, rgb=0.
REQ-023 Reset asserted mid-frame SHALL take effect immediately (asynchronous); after deassertion, the block SHALL wait in IDLE for count_en.

Verification
REQ-024 Defaults, count_en held 1 for 2 frames:
- 2200-cycle hsync period, 44 cycles high.
- vsync high for 5 lines.
- 1920x1080 rgb_valid cycles per frame.
- frame_cnt=2.
REQ-025 data_req vs rgb_valid: data_req rises 2 cycles before rgb_valid on each active line (first at h=190); pix_x runs 0..1919, pix_y 0..1079.
REQ-026 count_en dropped at line 500: the frame completes, busy falls after the last position, counters idle at 0, and frame_cnt increments once.
REQ-027 pat_sel=1 with data_in=24'h123456: pixel 0 is FFFFFF and pixel 240 is FFFF00. pat_sel switched to 3 mid-frame: FF0000 appears only from the next frame_start.
REQ-028 Small override (H_SYNC=2, H_BACK=3, H_VALID=8, H_FRONT=1, V 1/1/4/1, HS_POL=VS_POL=0): hsync is low for 2 of 14 cycles; rgb_valid is high for 32 cycles per 98-cycle frame.
REQ-029 sys_rst_n pulsed low mid-active-line: all outputs go to reset values asynchronously; after release with count_en=1, the first frame_start pulse occurs one cycle after RUN entry.
